one_hot_check: RTL and testbench

Receive-side companion to the one-hot sequence generator. It watches an 8-bit one-hot stream that advances one position per cycle with wrap-around, and encodes each word back to a binary index. It acquires and tracks the sequence, flags broken or out-of-order words, and keeps a saturating error count. It sits at the far end of the one-hot link and gives downstream logic a binary count plus lock and error status.

---
 rtl/one_hot_pkg.sv | 26 ++
 rtl/one_hot_to_bin.sv | 38 +++
 rtl/one_hot_check.sv | 134 +++++++++++++
 tb/tb_one_hot_check.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/one_hot_pkg.sv
// ============================================================================
// Module   : one_hot_pkg
// Purpose  : Shared types and constants for the one-hot link receiver.
//            Holds the checker state encoding, the one-hot word width and
//            the code reported for an illegal (not exactly one-hot) word.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package one_hot_pkg;

  localparam int ONE_HOT_W = 8;

  // Decode result for a word with zero bits or several bits set.
  localparam logic [3:0] c_ILLEGAL_CODE = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HUNT  = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

endpackage : one_hot_pkg

`default_nettype wire

// File: rtl/one_hot_to_bin.sv
// ============================================================================
// Module   : one_hot_to_bin
// Purpose  : Combinational 8-bit one-hot to binary encoder with a legality
//            flag. o_index is only meaningful while o_legal is high.
// Ports    : i_word  [7:0]  word to encode
//            o_index [2:0]  position of the set bit
//            o_legal        exactly one bit of i_word is set
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module one_hot_to_bin
  import one_hot_pkg::*;
(
  input  logic [ONE_HOT_W-1:0] i_word,
  output logic [2:0]           o_index,
  output logic                 o_legal
);

  logic [ONE_HOT_W-1:0] w_low_cleared;

  // Clearing the lowest set bit leaves zero only for a single-bit word.
  assign w_low_cleared = i_word & (i_word - ONE_HOT_W'(1));
  assign o_legal       = (i_word != '0) && (w_low_cleared == '0);

  // OR of the positions of all set bits; exact when the word is legal.
  always_comb begin
    o_index = 3'd0;
    for (int i = 0; i < ONE_HOT_W; i++) begin
      if (i_word[i]) begin
        o_index = o_index | 3'(i);
      end
    end
  end

endmodule : one_hot_to_bin

`default_nettype wire

// File: rtl/one_hot_check.sv
// ============================================================================
// Module   : one_hot_check
// Purpose  : Receive-side checker for a wrapping 8-bit one-hot sequence.
//            Decodes each word to binary, acquires and tracks the sequence,
//            reports lock, pulses err on a broken word and keeps a
//            saturating error count.
// Ports    : clk            rising-edge clock
//            nreset         synchronous active-low reset
//            go             check enable; low forces IDLE
//            one_hot1 [7:0] received word
//            count    [3:0] registered decode ({0,index} or 4'b1000)
//            locked         sequence lock indicator
//            err            one-cycle pulse on a tracking error
//            err_cnt        saturating error count since reset
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module one_hot_check
  import one_hot_pkg::*;
#(
  parameter int LOCK_N = 3,
  parameter int ERR_W  = 8
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 go,
  input  logic [ONE_HOT_W-1:0] one_hot1,
  output logic [3:0]           count,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_W-1:0]     err_cnt
);

  localparam logic [3:0] c_LOCK_GOOD = 4'(LOCK_N);

  state_t           r_state,    w_state_n;
  logic [2:0]       r_expected, w_expected_n;
  logic [3:0]       r_good,     w_good_n;
  logic [3:0]       w_count_n;
  logic             w_locked_n;
  logic             w_err_n;
  logic [ERR_W-1:0] w_err_cnt_n;

  logic [2:0]       w_index;
  logic             w_legal;
  logic [3:0]       w_code;

  one_hot_to_bin u_dec (
    .i_word  (one_hot1),
    .o_index (w_index),
    .o_legal (w_legal)
  );

  assign w_code = w_legal ? {1'b0, w_index} : c_ILLEGAL_CODE;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state    <= ST_IDLE;
      r_expected <= 3'd0;
      r_good     <= 4'd0;
      count      <= 4'd0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
    end else begin
      r_state    <= w_state_n;
      r_expected <= w_expected_n;
      r_good     <= w_good_n;
      count      <= w_count_n;
      locked     <= w_locked_n;
      err        <= w_err_n;
      err_cnt    <= w_err_cnt_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_expected_n = r_expected;
    w_good_n     = r_good;
    w_count_n    = w_code;
    w_locked_n   = locked;
    w_err_n      = 1'b0;
    w_err_cnt_n  = err_cnt;

    if (!go) begin
      // Enable low wins over everything: the word on this edge is not checked.
      w_state_n  = ST_IDLE;
      w_count_n  = 4'd0;
      w_locked_n = 1'b0;
      w_good_n   = 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // The word on this edge only feeds count; acquisition starts next edge.
          w_state_n  = ST_HUNT;
          w_locked_n = 1'b0;
        end

        ST_HUNT: begin
          w_locked_n = 1'b0;
          if (w_legal) begin
            w_expected_n = w_index + 3'd1;
            w_good_n     = 4'd1;
            w_state_n    = ST_TRACK;
            w_locked_n   = (c_LOCK_GOOD <= 4'd1);
          end
        end

        ST_TRACK: begin
          if (w_legal && (w_index == r_expected)) begin
            w_expected_n = r_expected + 3'd1;
            w_good_n     = (r_good >= c_LOCK_GOOD) ? c_LOCK_GOOD : r_good + 4'd1;
            w_locked_n   = (w_good_n >= c_LOCK_GOOD);
          end else begin
            w_err_n     = 1'b1;
            w_err_cnt_n = (&err_cnt) ? err_cnt : err_cnt + ERR_W'(1);
            w_locked_n  = 1'b0;
            w_good_n    = 4'd0;
            w_state_n   = ST_HUNT;
          end
        end

        default: begin
          w_state_n  = ST_IDLE;
          w_locked_n = 1'b0;
        end
      endcase
    end
  end

endmodule : one_hot_check

`default_nettype wire

// File: tb/tb_one_hot_check.sv
// ============================================================================
// Module   : tb_one_hot_check
// Purpose  : Directed self-checking bench for one_hot_check.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_one_hot_check;

  logic       clk = 1'b0;
  logic       nreset;
  logic       go;
  logic [7:0] one_hot1;
  logic [3:0] count;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  one_hot_check #(.LOCK_N(3), .ERR_W(8)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .go       (go),
    .one_hot1 (one_hot1),
    .count    (count),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic step(input logic [7:0] w, input logic g, input logic rn);
    nreset   = rn;
    go       = g;
    one_hot1 = w;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(8'h40, 1'b1, 1'b0);
    n_tests++; if (count !== 4'd0) begin $display("FAIL reset_count got %h exp 0", count); n_fail++; end
    n_tests++; if (locked !== 1'b0) begin $display("FAIL reset_locked got %b exp 0", locked); n_fail++; end
    n_tests++; if (err !== 1'b0) begin $display("FAIL reset_err got %b exp 0", err); n_fail++; end
    n_tests++; if (err_cnt !== 8'd0) begin $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); n_fail++; end
  endtask

  task automatic test_sequence();
    logic [7:0] words [9];
    logic [3:0] cexp  [9];
    logic       lexp  [9];
    words = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    cexp  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0};
    // First word only moves IDLE->HUNT; 02 acquires, 08 is the 3rd good word.
    lexp  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 9; i++) begin
      step(words[i], 1'b1, 1'b1);
      n_tests++; if (count !== cexp[i]) begin $display("FAIL seq_count[%0d] got %h exp %h", i, count, cexp[i]); n_fail++; end
      n_tests++; if (locked !== lexp[i]) begin $display("FAIL seq_locked[%0d] got %b exp %b", i, locked, lexp[i]); n_fail++; end
      n_tests++; if (err !== 1'b0) begin $display("FAIL seq_err[%0d] got %b exp 0", i, err); n_fail++; end
    end
  endtask

  // Expected index is 1 on entry.
  task automatic test_mismatch();
    step(8'h02, 1'b1, 1'b1);
    step(8'h04, 1'b1, 1'b1);
    step(8'h10, 1'b1, 1'b1);   // 0x08 expected
    exp_cnt = 1;
    n_tests++; if (count !== 4'd4) begin $display("FAIL mm_count got %h exp 4", count); n_fail++; end
    n_tests++; if (err !== 1'b1) begin $display("FAIL mm_err got %b exp 1", err); n_fail++; end
    n_tests++; if (err_cnt !== 8'(exp_cnt)) begin $display("FAIL mm_err_cnt got %0d exp %0d", err_cnt, exp_cnt); n_fail++; end
    n_tests++; if (locked !== 1'b0) begin $display("FAIL mm_locked got %b exp 0", locked); n_fail++; end
    step(8'h20, 1'b1, 1'b1);
    n_tests++; if (err !== 1'b0) begin $display("FAIL mm_err_pulse got %b exp 0", err); n_fail++; end
    n_tests++; if (locked !== 1'b0) begin $display("FAIL mm_relock1 got %b exp 0", locked); n_fail++; end
    step(8'h40, 1'b1, 1'b1);
    n_tests++; if (locked !== 1'b0) begin $display("FAIL mm_relock2 got %b exp 0", locked); n_fail++; end
    step(8'h80, 1'b1, 1'b1);
    n_tests++; if (locked !== 1'b1) begin $display("FAIL mm_relock3 got %b exp 1", locked); n_fail++; end
    n_tests++; if (count !== 4'd7) begin $display("FAIL mm_count3 got %h exp 7", count); n_fail++; end
  endtask

  // Expected index is 0 on entry.
  task automatic test_illegal();
    step(8'h00, 1'b1, 1'b1);
    exp_cnt = 2;
    n_tests++; if (count !== 4'b1000) begin $display("FAIL ill_zero_count got %h exp 8", count); n_fail++; end
    n_tests++; if (err !== 1'b1) begin $display("FAIL ill_zero_err got %b exp 1", err); n_fail++; end
    n_tests++; if (locked !== 1'b0) begin $display("FAIL ill_zero_locked got %b exp 0", locked); n_fail++; end
    step(8'h11, 1'b1, 1'b1);
    n_tests++; if (count !== 4'b1000) begin $display("FAIL ill_multi_count got %h exp 8", count); n_fail++; end
    n_tests++; if (err !== 1'b0) begin $display("FAIL ill_multi_err got %b exp 0", err); n_fail++; end
    n_tests++; if (err_cnt !== 8'(exp_cnt)) begin $display("FAIL ill_err_cnt got %0d exp %0d", err_cnt, exp_cnt); n_fail++; end
    step(8'h01, 1'b1, 1'b1);
    step(8'h02, 1'b1, 1'b1);
    step(8'h04, 1'b1, 1'b1);
    n_tests++; if (locked !== 1'b1) begin $display("FAIL ill_relock got %b exp 1", locked); n_fail++; end
  endtask

  // Expected index is 3 on entry, locked.
  task automatic test_go_drop();
    step(8'h08, 1'b0, 1'b1);
    n_tests++; if (count !== 4'd0) begin $display("FAIL go_count got %h exp 0", count); n_fail++; end
    n_tests++; if (locked !== 1'b0) begin $display("FAIL go_locked got %b exp 0", locked); n_fail++; end
    n_tests++; if (err !== 1'b0) begin $display("FAIL go_err got %b exp 0", err); n_fail++; end
    n_tests++; if (err_cnt !== 8'(exp_cnt)) begin $display("FAIL go_err_cnt got %0d exp %0d", err_cnt, exp_cnt); n_fail++; end
    step(8'h40, 1'b1, 1'b1);   // IDLE->HUNT, decode only, no check
    n_tests++; if (count !== 4'd6) begin $display("FAIL go_hunt_count got %h exp 6", count); n_fail++; end
    n_tests++; if (err !== 1'b0) begin $display("FAIL go_hunt_err got %b exp 0", err); n_fail++; end
    step(8'h80, 1'b1, 1'b1);
    step(8'h01, 1'b1, 1'b1);
    n_tests++; if (locked !== 1'b0) begin $display("FAIL go_relock2 got %b exp 0", locked); n_fail++; end
    step(8'h02, 1'b1, 1'b1);
    n_tests++; if (locked !== 1'b1) begin $display("FAIL go_relock3 got %b exp 1", locked); n_fail++; end
    n_tests++; if (err_cnt !== 8'(exp_cnt)) begin $display("FAIL go_err_cnt2 got %0d exp %0d", err_cnt, exp_cnt); n_fail++; end
  endtask

  // Alternate a broken word with a reacquiring word 260 times.
  task automatic test_saturation();
    for (int i = 0; i < 260; i++) begin
      step(8'h00, 1'b1, 1'b1);
      exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
      n_tests++; if (err !== 1'b1) begin $display("FAIL sat_err[%0d] got %b exp 1", i, err); n_fail++; end
      n_tests++; if (err_cnt !== 8'(exp_cnt)) begin $display("FAIL sat_err_cnt[%0d] got %0d exp %0d", i, err_cnt, exp_cnt); n_fail++; end
      step(8'h01, 1'b1, 1'b1);
    end
    n_tests++; if (err_cnt !== 8'd255) begin $display("FAIL sat_final got %0d exp 255", err_cnt); n_fail++; end
  endtask

  // Expected index is 1 on entry with one good word.
  task automatic test_reset_mid_track();
    step(8'h02, 1'b1, 1'b1);
    step(8'h04, 1'b1, 1'b1);
    n_tests++; if (locked !== 1'b1) begin $display("FAIL rst_pre_locked got %b exp 1", locked); n_fail++; end
    step(8'h40, 1'b1, 1'b0);   // bad word on the reset edge
    n_tests++; if (count !== 4'd0) begin $display("FAIL rst_count got %h exp 0", count); n_fail++; end
    n_tests++; if (locked !== 1'b0) begin $display("FAIL rst_locked got %b exp 0", locked); n_fail++; end
    n_tests++; if (err !== 1'b0) begin $display("FAIL rst_err got %b exp 0", err); n_fail++; end
    n_tests++; if (err_cnt !== 8'd0) begin $display("FAIL rst_err_cnt got %0d exp 0", err_cnt); n_fail++; end
    step(8'h01, 1'b1, 1'b1);
    n_tests++; if (err !== 1'b0) begin $display("FAIL rst_after_err got %b exp 0", err); n_fail++; end
    n_tests++; if (count !== 4'd0) begin $display("FAIL rst_after_count got %h exp 0", count); n_fail++; end
  endtask

  initial begin
    nreset   = 1'b0;
    go       = 1'b0;
    one_hot1 = 8'h00;
    @(negedge clk);
    test_reset();
    test_sequence();
    test_mismatch();
    test_illegal();
    test_go_drop();
    test_saturation();
    test_reset_mid_track();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_one_hot_check

`default_nettype wire
